// File: rtl/audio_fetch_sequencer_pkg.sv
// Shared types and defaults for the audio fetch sequencer and its sample FIFO.
package audio_fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  localparam int ADDR_W_DEFAULT = 16;
  localparam int DATA_W_DEFAULT = 16;

  // Cycles from the fetch unit seeing start to it raising its done flag.
  localparam int FETCH_LATENCY = 3;

endpackage

// File: rtl/audio_fetch_sequencer_fifo.sv
// First-word-fall-through sample FIFO with synchronous flush; the head reads as zero when empty.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Flush shares the reset path so a push in the same cycle is discarded.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/audio_fetch_sequencer.sv
// Walks a sample buffer through the single-word fetch unit and streams the words out of a FIFO.
module audio_fetch_sequencer
  import audio_fetch_sequencer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  output logic              fetch_start,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_clear,
  input  logic              fetch_done,
  input  logic [DATA_W-1:0] fetch_data,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] cur_addr;
  logic [15:0]       len_reg;
  logic [15:0]       remaining;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_push;
  logic              fifo_flush;
  logic              slot_free;
  logic              abort;

  // Nothing is in flight while in REQ, so the occupancy alone decides whether the
  // next fetch can reserve a slot; leaving REQ is what claims it.
  assign slot_free    = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign abort        = stop && (state != IDLE);
  assign fifo_push    = (state == CAPTURE) && !fifo_full;
  assign fifo_flush   = abort;
  assign sample_valid = !fifo_empty;
  assign busy         = (state != IDLE);

  sample_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_W)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .flush(fifo_flush),
    .push (fifo_push),
    .pop  (sample_valid && sample_ready),
    .din  (fetch_data),
    .dout (sample_data),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      base_reg    <= '0;
      len_reg     <= '0;
      cur_addr    <= '0;
      remaining   <= '0;
      fetch_start <= 1'b0;
      fetch_addr  <= '0;
      fetch_clear <= 1'b0;
      done        <= 1'b0;
    end else begin
      fetch_clear <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        fetch_start <= 1'b0;
        fetch_clear <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (play) begin
              if (length != '0) begin
                base_reg  <= base_addr;
                len_reg   <= length;
                cur_addr  <= base_addr;
                remaining <= length;
                state     <= REQ;
              end else begin
                done <= 1'b1;
              end
            end
          end
          REQ: begin
            if (slot_free) begin
              fetch_start <= 1'b1;
              fetch_addr  <= cur_addr;
              state       <= WAIT;
            end
          end
          WAIT: begin
            if (fetch_done) begin
              fetch_start <= 1'b0;
              fetch_clear <= 1'b1;
              state       <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (remaining != 16'd1) begin
              cur_addr  <= cur_addr + ADDR_W'(1);
              remaining <= remaining - 16'd1;
              state     <= REQ;
            end else if (loop_en) begin
              cur_addr  <= base_reg;
              remaining <= len_reg;
              state     <= REQ;
            end else begin
              cur_addr  <= cur_addr + ADDR_W'(1);
              remaining <= '0;
              state     <= DRAIN;
            end
          end
          DRAIN: begin
            if (fifo_empty) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_fetch_sequencer.sv
// Directed bench for audio_fetch_sequencer with a behavioural fetch unit returning mem[a] = a ^ 0xA5A5.
module tb_audio_fetch_sequencer;
  import audio_fetch_sequencer_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    int          exp_lat;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              play = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [15:0]       length = '0;
  logic              fetch_start;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_clear;
  logic              fetch_done;
  logic [DATA_W-1:0] fetch_data;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready = 1'b0;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] addr_q[$];
  logic [DATA_W-1:0] sample_q[$];
  int                done_cnt = 0;
  int                busy_cnt = 0;
  logic              prev_start = 1'b0;
  logic [1:0]        fu_cnt;

  vec_t vecs[4];

  always #5 clock = ~clock;

  audio_fetch_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .play        (play),
    .stop        (stop),
    .loop_en     (loop_en),
    .base_addr   (base_addr),
    .length      (length),
    .fetch_start (fetch_start),
    .fetch_addr  (fetch_addr),
    .fetch_clear (fetch_clear),
    .fetch_done  (fetch_done),
    .fetch_data  (fetch_data),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .busy        (busy),
    .done        (done)
  );

  // Fetch unit: done and data appear in the third cycle start is held, and stay until cleared.
  always @(posedge clock) begin
    if (reset || fetch_clear) begin
      fu_cnt     <= '0;
      fetch_done <= 1'b0;
      fetch_data <= '0;
    end else if (fetch_start && !fetch_done) begin
      if (fu_cnt == 2'(FETCH_LATENCY - 2)) begin
        fetch_done <= 1'b1;
        fetch_data <= fetch_addr ^ 16'hA5A5;
      end else begin
        fu_cnt <= fu_cnt + 2'd1;
      end
    end
  end

  always @(negedge clock) begin
    if (fetch_start && !prev_start) addr_q.push_back(fetch_addr);
    prev_start <= fetch_start;
    if (sample_valid && sample_ready) sample_q.push_back(sample_data);
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] base, input logic [15:0] len);
    @(posedge clock); #1;
    base_addr = base;
    length    = len;
    play      = 1'b1;
    @(posedge clock); #1;
    play = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output logic busy_at);
    bit got;
    got     = 0;
    lat     = 0;
    busy_at = 1'b1;
    while (!got && lat < budget) begin
      @(negedge clock);
      lat++;
      if (done) begin
        got     = 1;
        busy_at = busy;
      end
    end
  endtask

  task automatic check_run(input string tag, input int a0, input int s0,
                           input logic [15:0] base, input logic [15:0] len, input int n);
    logic [15:0] ea;
    check_output({tag, " fetches"}, addr_q.size() - a0, n);
    check_output({tag, " samples"}, sample_q.size() - s0, n);
    for (int i = 0; i < n; i++) begin
      ea = base + 16'(i % int'(len));
      if (a0 + i < addr_q.size())
        check_output($sformatf("%s addr%0d", tag, i), addr_q[a0 + i], ea);
      if (s0 + i < sample_q.size())
        check_output($sformatf("%s sample%0d", tag, i), sample_q[s0 + i], ea ^ 16'hA5A5);
    end
  endtask

  task automatic run_vector(input vec_t v, input string tag);
    int   a0, s0, d0, b0, lat;
    logic busy_at;
    a0 = addr_q.size();
    s0 = sample_q.size();
    d0 = done_cnt;
    b0 = busy_cnt;
    sample_ready = 1'b1;
    loop_en      = 1'b0;
    apply_stimulus(v.base, v.len);
    wait_done(300, lat, busy_at);
    check_output({tag, " latency"}, lat, v.exp_lat);
    check_output({tag, " busy at done"}, busy_at, 1'b0);
    repeat (3) @(negedge clock);
    check_output({tag, " done pulses"}, done_cnt - d0, 1);
    check_output({tag, " busy seen"}, busy_cnt != b0, v.len != 0);
    check_run(tag, a0, s0, v.base, v.len, int'(v.len));
  endtask

  task automatic check_idle_zero(input string tag);
    check_output({tag, " fetch_start"}, fetch_start, 1'b0);
    check_output({tag, " fetch_addr"}, fetch_addr, 16'h0000);
    check_output({tag, " fetch_clear"}, fetch_clear, 1'b0);
    check_output({tag, " sample_valid"}, sample_valid, 1'b0);
    check_output({tag, " sample_data"}, sample_data, 16'h0000);
    check_output({tag, " busy"}, busy, 1'b0);
    check_output({tag, " done"}, done, 1'b0);
  endtask

  initial begin
    int   a0, s0, d0, lat, k;
    logic busy_at;

    // Latency = cycles from the first cycle after play to the cycle done is seen: 5 per word + 3.
    vecs[0] = '{16'h0100, 16'd3, 18};
    vecs[1] = '{16'h1234, 16'd1, 8};
    vecs[2] = '{16'h00FF, 16'd2, 13};
    vecs[3] = '{16'h5555, 16'd0, 1};

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_idle_zero("reset");

    for (int i = 0; i < 4; i++) run_vector(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: only FIFO_DEPTH fetches may issue while the consumer stalls.
    a0 = addr_q.size(); s0 = sample_q.size(); d0 = done_cnt;
    sample_ready = 1'b0;
    apply_stimulus(16'h0200, 16'd8);
    repeat (60) @(negedge clock);
    check_output("bp stalled fetches", addr_q.size() - a0, 4);
    check_output("bp fetch_start idle", fetch_start, 1'b0);
    check_output("bp sample_valid", sample_valid, 1'b1);
    @(posedge clock); #1 sample_ready = 1'b1;
    wait_done(300, lat, busy_at);
    check_output("bp done seen", done, 1'b1);
    repeat (3) @(negedge clock);
    check_output("bp done pulses", done_cnt - d0, 1);
    check_run("bp", a0, s0, 16'h0200, 16'd8, 8);

    // Looping across the address wrap, then ending after the second pass.
    a0 = addr_q.size(); s0 = sample_q.size(); d0 = done_cnt;
    sample_ready = 1'b1;
    loop_en      = 1'b1;
    apply_stimulus(16'hFFFE, 16'd3);
    k = 0;
    while (addr_q.size() - a0 < 5 && k < 100) begin
      @(negedge clock);
      k++;
    end
    @(posedge clock); #1 loop_en = 1'b0;
    wait_done(200, lat, busy_at);
    check_output("loop done seen", done, 1'b1);
    repeat (3) @(negedge clock);
    check_output("loop done pulses", done_cnt - d0, 1);
    check_run("loop", a0, s0, 16'hFFFE, 16'd3, 6);

    // Abort during WAIT of the second word with one sample queued.
    a0 = addr_q.size(); d0 = done_cnt;
    sample_ready = 1'b0;
    apply_stimulus(16'h0300, 16'd4);
    k = 0;
    while (addr_q.size() - a0 < 2 && k < 100) begin
      @(negedge clock);
      k++;
    end
    check_output("abort queued", sample_valid, 1'b1);
    @(posedge clock); #1 stop = 1'b1;
    @(posedge clock); #1 stop = 1'b0;
    @(negedge clock);
    check_output("abort busy", busy, 1'b0);
    check_output("abort sample_valid", sample_valid, 1'b0);
    check_output("abort fetch_clear", fetch_clear, 1'b1);
    check_output("abort fetch_start", fetch_start, 1'b0);
    check_output("abort done", done, 1'b0);
    repeat (10) @(negedge clock);
    check_output("abort no done", done_cnt - d0, 0);
    check_output("abort fetches", addr_q.size() - a0, 2);
    run_vector('{16'h0300, 16'd2, 13}, "restart");

    // Synchronous reset landing on a CAPTURE cycle.
    sample_ready = 1'b1;
    apply_stimulus(16'h0400, 16'd3);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!(fetch_clear && busy) && k < 50);
    check_output("reset hit capture", fetch_clear && busy, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_idle_zero("midrun reset");
    run_vector('{16'h0500, 16'd2, 13}, "post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_fetch_sequencer.md
Name: audio_fetch_sequencer

Overview:
- Upstream controller for the single-word memory fetch unit.
- Walks a sample buffer from base_addr for length words, issuing one fetch per word. Clears the fetch unit between words, because that unit parks in its END state until reset.
- Queues the returned 16-bit samples in a small FIFO and presents them to the audio output stage over a valid/ready interface.
- Supports one-shot and looping playback, plus abort.

Parameters:
- FIFO_DEPTH, 4, sample FIFO entries; power of two, at least 2.
- ADDR_W, 16, memory address width.
- DATA_W, 16, sample width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- play  in  1  one-cycle start pulse; sampled only in IDLE
- stop  in  1  one-cycle abort pulse; honoured in any non-IDLE state
- loop_en  in  1  restart at base_addr after the last word; sampled continuously
- base_addr  in  ADDR_W  first sample address; latched on play
- length  in  16  number of words; latched on play
- fetch_start  out  1  start request to the fetch unit
- fetch_addr  out  ADDR_W  address presented to the fetch unit
- fetch_clear  out  1  one-cycle return-to-IDLE pulse, OR'd into the fetch unit reset
- fetch_done  in  1  fetch unit end flag (level)
- fetch_data  in  DATA_W  fetch unit registered data out
- sample_data  out  DATA_W  FIFO head
- sample_valid  out  1  FIFO not empty
- sample_ready  in  1  consumer accepts; a pop occurs on valid && ready
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when one-shot playback fully drains

Behaviour:
- Reset values:
  - all outputs 0; FIFO empty.
  - cur_addr = 0, remaining = 0, state = IDLE.
  - fetch_clear = 1 during reset is not required.
- States: IDLE, REQ, WAIT, CAPTURE, DRAIN.
- IDLE:
  - play with length != 0: latch base and length, set cur_addr = base_addr, remaining = length, go to REQ.
  - play with length == 0: pulse done next cycle; stay in IDLE; no fetch issued.
- REQ:
  - Entered only when the FIFO has at least one free slot, counting the entry in flight. Otherwise wait in REQ with fetch_start = 0.
  - When a slot is free: fetch_start = 1, fetch_addr = cur_addr, go to WAIT.
- WAIT:
  - fetch_start and fetch_addr held until fetch_done = 1. The fetch unit responds with done 3 cycles after start.
  - On fetch_done: go to CAPTURE.
- CAPTURE (1 cycle):
  - Push fetch_data into the FIFO.
  - fetch_clear = 1, fetch_start = 0.
  - cur_addr += 1, wrapping modulo 2^ADDR_W; remaining -= 1.
  - Next state:
    - remaining (pre-decrement) != 1: REQ.
    - remaining == 1 and loop_en = 1: reload cur_addr = base and remaining = length, then REQ.
    - otherwise: DRAIN.
- DRAIN:
  - Wait for the FIFO to empty through consumer pops.
  - When empty: done = 1 for one cycle, go to IDLE.
- Throughput: one word per 5 cycles (REQ, 3 x WAIT, CAPTURE) when the consumer keeps up.
- Simultaneous events:
  - A FIFO push and pop in the same cycle are both legal; occupancy is unchanged.
  - A full FIFO never sees a push, because REQ reserves the slot.
- stop in any non-IDLE state:
  - Next cycle: state = IDLE, FIFO flushed, fetch_clear = 1 for that cycle.
  - No done pulse.
  - An in-flight fetch_done is ignored.
- stop and play in the same cycle while IDLE: play wins.
- play while busy: ignored.
- reset mid-operation: immediate return to reset values; the fetch unit is reset by the same signal.
- fetch_done arriving outside WAIT: ignored.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE, REQ, WAIT, CAPTURE, DRAIN)
  - ADDR_W and DATA_W defaults
  - FETCH_LATENCY = 3
- Sub-module sample_fifo:
  - Parameters DEPTH and WIDTH.
  - Ports: push, pop, din, dout, empty, full, count, flush.
  - First-word fall-through; synchronous flush.
- The top level holds the FSM, address/remaining counters, and the slot reservation.

Test Plan:
- One-shot run: base = 0x0100, length = 3, sample_ready tied 1, model returns mem[a] = a ^ 0xA5A5.
  - fetch_addr shows 0x0100, 0x0101, 0x0102.
  - Samples arrive in order: 0xA4A5, 0xA4A4, 0xA4A7.
  - done pulses once; busy falls in the same cycle it returns to IDLE.
  - Each word takes 5 cycles.
- Backpressure: length = 8, FIFO_DEPTH = 4, sample_ready = 0 until cycle 60.
  - Exactly 4 fetches issued; fetch_start stays 0 afterwards.
  - When ready rises, all 8 samples delivered in order, then done.
- Loop and wrap: base = 0xFFFE, length = 3, loop_en = 1.
  - Addresses 0xFFFE, 0xFFFF, 0x0000, 0xFFFE, ...
  - Clearing loop_en mid-pass ends after that pass's 3rd word with done.
- Zero length: play with length = 0.
  - done pulses 1 cycle later; fetch_start never asserted; busy stays 0.
- Abort: stop during WAIT of the 2nd word, with 1 sample queued.
  - Next cycle: IDLE, sample_valid = 0, fetch_clear = 1, no done.
  - A new play then starts cleanly from base.
- Reset mid-run: reset asserted in CAPTURE.
  - All outputs 0 next cycle; FIFO empty; a subsequent play fetches from the new base.
